// File: rtl/cache_pkg.sv
// ----------------------------------------------------------------------------
// cache_pkg
// Shared types and constants for the data-cache refill / write-through
// controller:
//   refill_state_t : miss-handler FSM states
//   wb_entry_t     : one posted write {addr, data, is_byte}
//   WORD_MASK      : clears the byte offset of a byte address
//   word_align()   : helper applying WORD_MASK
// ----------------------------------------------------------------------------
package cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_RD_REQ  = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_FILL    = 3'd4
    } refill_state_t;

    // 'byte' is a keyword, so the byte-store flag is called is_byte.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        is_byte;
    } wb_entry_t;

    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & WORD_MASK;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// ----------------------------------------------------------------------------
// wb_fifo
// Synchronous FIFO of posted writes (wb_entry_t), DEPTH entries (power of
// two, >= 2). Push and pop may happen in the same cycle, including when the
// FIFO is full (the pop frees the slot the push uses).
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   push_i    : enqueue din_i (ignored when full and not popping)
//   din_i     : entry to enqueue
//   pop_i     : dequeue the head (ignored when empty)
//   head_o    : oldest entry
//   full_o    : DEPTH entries stored
//   empty_o   : no entries stored
//   count_o   : number of entries stored
// ----------------------------------------------------------------------------
module wb_fifo
    import cache_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  wb_entry_t        din_i,
    input  logic             pop_i,
    output wb_entry_t        head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    wb_entry_t        mem_q [DEPTH];
    wb_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_s, do_pop_s;

    assign do_pop_s  = pop_i & (count_q != {CNT_W{1'b0}});
    assign do_push_s = push_i & ((count_q != FULL_CNT) | do_pop_s);

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == {CNT_W{1'b0}});
    assign count_o = count_q;

    // Next-state computation for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = din_i;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers; reset empties the buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '{addr: 32'h0, data: 32'h0, is_byte: 1'b0};
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/cache_refill_ctrl.sv
// ----------------------------------------------------------------------------
// cache_refill_ctrl
// Miss handler and write-through controller between the M-stage
// direct-mapped data cache and a multi-cycle data memory.
//   - Load miss: stall, drain posted writes, read the word, pulse the cache
//     refill port for one cycle, then release the stall so the retry hits.
//   - Store: posted into a WB_DEPTH-entry write buffer; stalls only when full.
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   access_i, is_store_i,
//   byte_i, addr_i, wdata_i   : M-stage memory instruction
//   cache_hit_i               : cache hit for addr_i
//   stall_o                   : freeze PC..M registers
//   refill_en_o/addr_o/data_o : cache refill port (one-cycle pulse)
//   mem_req_o, mem_we_o,
//   mem_byte_o, mem_addr_o,
//   mem_wdata_o               : memory request, held until mem_ack_i
//   mem_ack_i, mem_rdata_i    : one-cycle acknowledge with read data
// ----------------------------------------------------------------------------
module cache_refill_ctrl
    import cache_pkg::*;
#(
    parameter int WB_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        access_i,
    input  logic        is_store_i,
    input  logic        byte_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        cache_hit_i,
    output logic        stall_o,
    output logic        refill_en_o,
    output logic [31:0] refill_addr_o,
    output logic [31:0] refill_data_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic        mem_byte_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int CNT_W = $clog2(WB_DEPTH) + 1;

    refill_state_t    state_q, state_d;
    logic [31:0]      miss_addr_q, miss_addr_d;
    logic [31:0]      fill_data_q, fill_data_d;

    wb_entry_t        wb_din_s, wb_head_s;
    logic             wb_push_s, wb_pop_s, wb_full_s, wb_empty_s;
    logic [CNT_W-1:0] wb_count_s;

    logic             load_miss_s, store_s, wb_busy_s, wr_present_s;
    logic             stall_s;

    assign load_miss_s = access_i & ~is_store_i & ~cache_hit_i;
    assign store_s     = access_i & is_store_i;
    // A buffered write stays at the head until acked, so a non-empty buffer
    // also covers the write that is currently in flight.
    assign wb_busy_s   = (wb_count_s != {CNT_W{1'b0}});

    // Buffered writes are only presented while no read is in progress.
    assign wr_present_s = ((state_q == ST_IDLE) | (state_q == ST_DRAIN)) & ~wb_empty_s;
    assign wb_pop_s     = wr_present_s & mem_ack_i;
    // A pop in the same cycle frees a slot, so a store at full still goes in.
    assign wb_push_s    = (state_q == ST_IDLE) & store_s & (~wb_full_s | wb_pop_s);
    assign wb_din_s     = '{addr: addr_i, data: wdata_i, is_byte: byte_i};

    wb_fifo #(
        .DEPTH (WB_DEPTH)
    ) u_wb_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (wb_push_s),
        .din_i   (wb_din_s),
        .pop_i   (wb_pop_s),
        .head_o  (wb_head_s),
        .full_o  (wb_full_s),
        .empty_o (wb_empty_s),
        .count_o (wb_count_s)
    );

    // Next state of the miss FSM and of the latched refill address/data.
    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        fill_data_d = fill_data_q;
        case (state_q)
            ST_IDLE: begin
                if (load_miss_s) begin
                    miss_addr_d = word_align(addr_i);
                    state_d     = wb_busy_s ? ST_DRAIN : ST_RD_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (!wb_busy_s) begin
                    state_d = ST_RD_REQ;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_RD_REQ, ST_RD_WAIT: begin
                if (mem_ack_i) begin
                    fill_data_d = mem_rdata_i;
                    state_d     = ST_FILL;
                end else begin
                    state_d = ST_RD_WAIT;
                end
            end
            ST_FILL: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from the current state, buffer head and M-stage inputs.
    always_comb begin
        stall_s       = 1'b0;
        refill_en_o   = 1'b0;
        refill_addr_o = 32'h0;
        refill_data_o = 32'h0;
        mem_req_o     = 1'b0;
        mem_we_o      = 1'b0;
        mem_byte_o    = 1'b0;
        mem_addr_o    = 32'h0;
        mem_wdata_o   = 32'h0;
        case (state_q)
            ST_IDLE: begin
                stall_s = load_miss_s | (store_s & wb_full_s & ~wb_pop_s);
            end
            ST_DRAIN: begin
                stall_s = 1'b1;
            end
            ST_RD_REQ: begin
                stall_s    = 1'b1;
                mem_req_o  = 1'b1;
                mem_addr_o = word_align(addr_i);
            end
            ST_RD_WAIT: begin
                stall_s    = 1'b1;
                mem_req_o  = 1'b1;
                mem_addr_o = miss_addr_q;
            end
            ST_FILL: begin
                stall_s       = 1'b1;
                refill_en_o   = 1'b1;
                refill_addr_o = miss_addr_q;
                refill_data_o = fill_data_q;
            end
            default: begin
                stall_s = 1'b0;
            end
        endcase
        if (wr_present_s) begin
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            mem_byte_o  = wb_head_s.is_byte;
            mem_addr_o  = wb_head_s.addr;
            mem_wdata_o = wb_head_s.data;
        end else begin
            mem_we_o = 1'b0;
        end
    end

    // stall_o is the only output that follows the M-stage inputs directly in
    // IDLE; masking it keeps every output at 0 while reset is held.
    assign stall_o = stall_s & ~rst;

    // Miss FSM and latched refill address/data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            miss_addr_q <= 32'h0;
            fill_data_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            fill_data_q <= fill_data_d;
        end
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
module tb_cache_refill_ctrl;

    localparam int WB_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        access_i, is_store_i, byte_i, cache_hit_i;
    logic [31:0] addr_i, wdata_i;
    logic        stall_o, refill_en_o;
    logic [31:0] refill_addr_o, refill_data_o;
    logic        mem_req_o, mem_we_o, mem_byte_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    cache_refill_ctrl #(.WB_DEPTH(WB_DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .access_i      (access_i),
        .is_store_i    (is_store_i),
        .byte_i        (byte_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .cache_hit_i   (cache_hit_i),
        .stall_o       (stall_o),
        .refill_en_o   (refill_en_o),
        .refill_addr_o (refill_addr_o),
        .refill_data_o (refill_data_o),
        .mem_req_o     (mem_req_o),
        .mem_we_o      (mem_we_o),
        .mem_byte_o    (mem_byte_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_ack_i     (mem_ack_i),
        .mem_rdata_i   (mem_rdata_i)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, required 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference models ----------------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        is_byte;
    } st_t;

    logic [31:0] mem_arr [int];   // contents the memory device actually holds
    logic [31:0] ref_mem [int];   // architectural contents (program order)
    logic [31:0] cache_m [int];   // words currently valid in the cache
    st_t         exp_q[$];        // stores retired but not yet written to memory

    // memory responder state
    bit          busy;
    int          wait_cnt, cur_lat;
    int          fixed_lat = -1;
    logic [33:0] snap_ctl;
    logic [31:0] snap_wd;

    // per-cycle observations
    logic        last_stall, last_fill;
    logic [31:0] fill_addr_seen, fill_data_seen;
    logic [31:0] last_wr_addr;
    logic        last_wr_byte;

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] mem_get(input int i);
        if (mem_arr.exists(i)) return mem_arr[i];
        return init_word(i);
    endfunction

    function automatic logic [31:0] ref_get(input int i);
        if (ref_mem.exists(i)) return ref_mem[i];
        return init_word(i);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] a,
                                          input logic [31:0] d, input logic b);
        logic [31:0] r;
        if (!b) return d;
        r = old;
        r[{a[1:0], 3'b000} +: 8] = d[7:0];
        return r;
    endfunction

    // One clock cycle: called at a negedge with M-stage inputs already set.
    task automatic cycle();
        #1;
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'h0;
        if (busy && !mem_req_o) begin
            check("req_held", 64'(mem_req_o), 64'(1));
            busy = 0;
        end
        if (mem_req_o) begin
            if (!busy) begin
                busy     = 1;
                wait_cnt = 0;
                cur_lat  = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 4));
                snap_ctl = {mem_we_o, mem_byte_o, mem_addr_o};
                snap_wd  = mem_wdata_o;
                if (!mem_we_o) begin
                    check("rd_addr", 64'(mem_addr_o), 64'({addr_i[31:2], 2'b00}));
                    check("rd_after_writes", 64'(exp_q.size()), 64'(0));
                end
            end else begin
                check("req_stable_ctl", 64'({mem_we_o, mem_byte_o, mem_addr_o}), 64'(snap_ctl));
                check("req_stable_wdata", 64'(mem_wdata_o), 64'(snap_wd));
            end
            if (wait_cnt == cur_lat) begin
                mem_ack_i = 1'b1;
                if (!mem_we_o) mem_rdata_i = mem_get(int'(mem_addr_o[31:2]));
            end
        end
        #1;
        last_stall = stall_o;
        last_fill  = refill_en_o;
        if (refill_en_o) begin
            check("fill_addr", 64'(refill_addr_o), 64'({addr_i[31:2], 2'b00}));
            cache_m[int'(refill_addr_o[31:2])] = refill_data_o;
            fill_addr_seen = refill_addr_o;
            fill_data_seen = refill_data_o;
        end
        if (mem_ack_i) begin
            if (mem_we_o) begin
                if (exp_q.size() == 0) begin
                    check("wr_unexpected", 64'(0), 64'(1));
                end else begin
                    st_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", 64'(mem_addr_o), 64'(e.addr));
                    check("wr_data", 64'(mem_wdata_o), 64'(e.data));
                    check("wr_byte", 64'(mem_byte_o), 64'(e.is_byte));
                end
                mem_arr[int'(mem_addr_o[31:2])] =
                    merge(mem_get(int'(mem_addr_o[31:2])), mem_addr_o, mem_wdata_o, mem_byte_o);
                last_wr_addr = mem_addr_o;
                last_wr_byte = mem_byte_o;
            end
            busy = 0;
        end else if (busy) begin
            wait_cnt++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present one memory instruction until the pipeline is released.
    task automatic run_op(input logic st, input logic by, input logic [31:0] a,
                          input logic [31:0] d, output int stalls, output int fills);
        int idx;
        bit was_miss;
        bit done;
        idx      = int'(a[31:2]);
        was_miss = !cache_m.exists(idx);
        access_i = 1'b1; is_store_i = st; byte_i = by; addr_i = a; wdata_i = d;
        stalls = 0; fills = 0; done = 0;
        for (int n = 0; n < 100 && !done; n++) begin
            cache_hit_i = cache_m.exists(idx);
            cycle();
            fills += int'(last_fill);
            if (last_stall) begin
                stalls++;
            end else begin
                done = 1;
                if (st) begin
                    exp_q.push_back('{addr: a, data: d, is_byte: by});
                    ref_mem[idx] = merge(ref_get(idx), a, d, by);
                    if (cache_m.exists(idx)) cache_m[idx] = merge(cache_m[idx], a, d, by);
                    check("st_fills", 64'(fills), 64'(0));
                end else begin
                    check("ld_hit", 64'(cache_hit_i), 64'(1));
                    if (cache_m.exists(idx)) check("ld_data", 64'(cache_m[idx]), 64'(ref_get(idx)));
                    check("ld_fills", 64'(fills), 64'(was_miss));
                end
            end
        end
        if (!done) check("op_timeout", 64'(0), 64'(1));
        access_i = 1'b0; is_store_i = 1'b0; byte_i = 1'b0; cache_hit_i = 1'b0;
    endtask

    task automatic idle(input int n);
        access_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            cycle();
            check("idle_stall", 64'(last_stall), 64'(0));
        end
    endtask

    task automatic drain();
        access_i = 1'b0;
        for (int i = 0; i < 100 && (exp_q.size() != 0 || busy); i++) cycle();
        check("drain_done", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic check_outputs_zero(input string where);
        check({where, "_ctl"}, 64'({stall_o, refill_en_o, mem_req_o, mem_we_o, mem_byte_o}), 64'(0));
        check({where, "_refill"}, {refill_addr_o, refill_data_o}, 64'(0));
        check({where, "_mem"}, {mem_addr_o, mem_wdata_o}, 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, f;
        rst = 1'b1; access_i = 1'b0; is_store_i = 1'b0; byte_i = 1'b0; cache_hit_i = 1'b0;
        addr_i = 32'h0; wdata_i = 32'h0; mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
        busy = 0; wait_cnt = 0; cur_lat = 0;
        repeat (2) @(negedge clk);
        #1 check_outputs_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        #1 check_outputs_zero("post_reset");
        @(negedge clk);
        idle(2);

        // Load miss, ack 2 cycles after the first request cycle.
        fixed_lat = 2;
        mem_arr[32'h100 >> 2] = 32'hDEAD_BEEF;
        ref_mem[32'h100 >> 2] = 32'hDEAD_BEEF;
        run_op(1'b0, 1'b0, 32'h0000_0100, 32'h0, s, f);
        check("miss_stalls", 64'(s), 64'(5));
        check("miss_fills", 64'(f), 64'(1));
        check("miss_fill_addr", 64'(fill_addr_seen), 64'(32'h100));
        check("miss_fill_data", 64'(fill_data_seen), 64'(32'hDEAD_BEEF));
        idle(1);

        // Zero-latency ack.
        fixed_lat = 0;
        run_op(1'b0, 1'b0, 32'h0000_0200, 32'h0, s, f);
        check("zero_lat_stalls", 64'(s), 64'(3));
        idle(1);

        // Store burst against a full two-entry buffer.
        fixed_lat = 4;
        run_op(1'b1, 1'b0, 32'h0000_0010, 32'hA1A1_0001, s, f);
        check("burst_st1_stalls", 64'(s), 64'(0));
        run_op(1'b1, 1'b0, 32'h0000_0014, 32'hA1A1_0002, s, f);
        check("burst_st2_stalls", 64'(s), 64'(0));
        run_op(1'b1, 1'b0, 32'h0000_0018, 32'hA1A1_0003, s, f);
        check("burst_st3_stalls", 64'(s), 64'(3));
        drain();

        // Load miss behind a buffered store must drain first.
        fixed_lat = 3;
        run_op(1'b1, 1'b0, 32'h0000_0040, 32'h1122_3344, s, f);
        run_op(1'b0, 1'b0, 32'h0000_0080, 32'h0, s, f);
        check("drain_load_stalls", 64'(s), 64'(10));
        check("drain_mem_word", 64'(mem_get(32'h40 >> 2)), 64'(32'h1122_3344));
        idle(1);

        // Byte store.
        fixed_lat = 1;
        run_op(1'b1, 1'b1, 32'h0000_0103, 32'h5555_55AB, s, f);
        drain();
        check("sb_byte", 64'(last_wr_byte), 64'(1));
        check("sb_addr", 64'(last_wr_addr), 64'(32'h103));
        check("sb_mem_word", 64'(mem_get(32'h100 >> 2)), 64'(32'hABAD_BEEF));

        // Reset while waiting for read data.
        fixed_lat = 20;
        access_i = 1'b1; is_store_i = 1'b0; byte_i = 1'b0; addr_i = 32'h300; cache_hit_i = 1'b0;
        repeat (3) cycle();
        rst = 1'b1;
        #1 check_outputs_zero("mid_miss_reset");
        busy = 0;
        access_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD0_BAD0;
        #1;
        check("late_ack_req", 64'(mem_req_o), 64'(0));
        check("late_ack_stall", 64'(stall_o), 64'(0));
        @(negedge clk);
        mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
        #1 check("late_ack_fill", 64'(refill_en_o), 64'(0));
        @(negedge clk);
        fixed_lat = 1;
        run_op(1'b0, 1'b0, 32'h0000_0300, 32'h0, s, f);
        check("after_reset_stalls", 64'(s), 64'(4));
        check("after_reset_fill", 64'(fill_data_seen), 64'(init_word(32'h300 >> 2)));
        idle(1);

        // Randomised traffic.
        fixed_lat = -1;
        for (int i = 0; i < 400; i++) begin
            logic        st, by;
            logic [31:0] a;
            if ($urandom_range(0, 3) == 0) cache_m.delete(int'($urandom_range(0, 15)));
            st = 1'($urandom_range(0, 1));
            by = 1'($urandom_range(0, 1));
            a  = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
            if (by) a[1:0] = 2'($urandom_range(0, 3));
            run_op(st, by, a, $urandom, s, f);
            idle(int'($urandom_range(0, 2)));
        end
        drain();
        foreach (ref_mem[k]) check("mem_final", 64'(mem_get(k)), 64'(ref_mem[k]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_refill_ctrl.md
# cache_refill_ctrl

Miss handler and write-through controller between the M-stage direct-mapped data cache and the multi-cycle data memory. On a load miss, it stalls the pipeline and fetches the word from memory. It then drives the cache's refill port so the retried access hits. Stores are written through to memory via a small posted write buffer, so they only stall when the buffer is full.

## Interface
- `WB_DEPTH`, 2: write-buffer entries (power of two, ≥2)
- `clk`  in  1  sole clock; all state updates on posedge
- `rst`  in  1  asynchronous, active-high reset
- `access_i`  in  1  M-stage memory instruction valid
- `is_store_i`  in  1  1 = sw/sb, 0 = lw/lb/lbu
- `byte_i`  in  1  1 = byte access (sb), 0 = word
- `addr_i`  in  32  byte address
- `wdata_i`  in  32  store data (byte in [7:0] for sb)
- `cache_hit_i`  in  1  cache hit for `addr_i` (valid when `access_i`)
- `stall_o`  out  1  freeze PC..M registers
- `refill_en_o`  out  1  cache refill enable, one-cycle pulse
- `refill_addr_o`  out  32  word-aligned refill address
- `refill_data_o`  out  32  refill word
- `mem_req_o`  out  1  memory request; held until `mem_ack_i`
- `mem_we_o`  out  1  1 = write, 0 = read
- `mem_byte_o`  out  1  byte write
- `mem_addr_o`  out  32  memory address
- `mem_wdata_o`  out  32  memory write data
- `mem_ack_i`  in  1  one-cycle acknowledge; `mem_rdata_i` valid with it
- `mem_rdata_i`  in  32  read word

## Operation
- FSM states: IDLE, DRAIN, RD_REQ, RD_WAIT, FILL.
- **IDLE, load hit:** no action.
- **IDLE, load miss** (`access_i & ~is_store_i & ~cache_hit_i`):
  - `stall_o`=1 combinationally.
  - Next state is DRAIN if the buffer is non-empty or a write is in flight; otherwise RD_REQ.
- **DRAIN:** `stall_o`=1. Move to RD_REQ when the buffer is empty and no write is outstanding. Reads never bypass buffered writes.
- **RD_REQ:**
  - Drive `mem_req_o`=1, `mem_we_o`=0, `mem_addr_o`={addr_i[31:2],2'b00}. Then go to RD_WAIT.
  - If `mem_ack_i` arrives in the same cycle, latch the data and go straight to FILL.
- **RD_WAIT:** hold the request. On `mem_ack_i`, latch `mem_rdata_i` and go to FILL.
- **FILL:** `refill_en_o`=1, with `refill_addr_o`/`refill_data_o` from the latched values; `stall_o`=1. Next state is IDLE, where the retried access hits.
- **Store in IDLE:**
  - If the buffer is not full, enqueue {addr, data, byte} with no stall.
  - If it is full, `stall_o`=1 and no enqueue. Retry next cycle.
  - Same-cycle pop+push at full is allowed, giving no stall.
  - Store hit/miss has no effect here; the cache updates itself.
- **Buffer drain:**
  - In IDLE or DRAIN with the buffer non-empty, present the head: `mem_req_o`=1, `mem_we_o`=1, `mem_byte_o`, addr, data.
  - Pop on `mem_ack_i`.
  - A write in flight is never aborted by a load miss. The FSM waits in DRAIN.
- Stores enqueue only while `stall_o`=0, so a stalled store is never enqueued twice.

## Timing
- Reset value of every output is 0. FSM resets to IDLE. The buffer is emptied and pointers and count are cleared.
- Reset during RD_WAIT or a buffered write abandons the transaction. A late `mem_ack_i` is ignored in IDLE unless a request is outstanding.
- Load-miss latency, empty buffer, with ack k cycles after the first request cycle (k ≥ 0):
  - Stall cycles = k + 3 (miss/IDLE, RD_REQ..ack, FILL).
  - The access completes on the cycle after FILL.
- `mem_req_o` and its address, data and `we` are stable from assertion until the ack cycle inclusive.
- `refill_en_o` is high for exactly one cycle per miss.

## Structure
- `cache_pkg` holds:
  - `refill_state_t` enum
  - `wb_entry_t` struct {addr[31:0], data[31:0], byte}
  - `WORD_MASK` constant
- Sub-module `wb_fifo`:
  - Parametrised synchronous FIFO of `wb_entry_t`, depth `WB_DEPTH`.
  - Exposes full/empty and count, and allows push+pop in the same cycle.
  - Asynchronous `rst`.

## Test plan
- **Load miss:** lw 0x100, miss, ack after 2 cycles returning 0xDEADBEEF → stall 5 cycles, one `refill_en_o` pulse with addr 0x100 and data 0xDEADBEEF, then stall drops.
- **Store burst:** 3 back-to-back sw, `WB_DEPTH`=2, memory acks 4 cycles after request → first two enqueue without stall, third stalls until the first ack, memory sees writes in order.
- **Load after store:** sw 0x40 ← 0x11223344, then lw 0x80 misses → read request issued only after the 0x40 write ack (DRAIN observed).
- **Byte store:** sb 0x103 ← 0xAB → memory write with `mem_byte_o`=1, addr 0x103, data[7:0]=0xAB.
- **Reset mid-miss:** assert `rst` in RD_WAIT → all outputs 0 immediately, later ack ignored, next miss handled normally.
- **Zero-latency ack:** ack in the same cycle as RD_REQ → FILL follows directly, total stall 3 cycles.
